mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates a single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences one outstanding memory transaction at a time over a variable-latency cmd/ack bus.
- Returns fetched instructions and load data to the requesting stage.
- Drives a stall request into the stalling module while any requester waits.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of instruction and data paths.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  IF stage requests a fetch at if_addr
- if_addr  in  ADDR_W  fetch address (IF_pc)
- if_vld  out  1  fetch complete; if_inst valid this cycle
- if_inst  out  DATA_W  fetched instruction
- dm_cmd  in  2  MEM stage command, `BUS_NONE/`BUS_LOAD/`BUS_STORE
- dm_addr  in  ADDR_W  data address
- dm_din  in  DATA_W  store data
- dm_done  out  1  data transaction complete this cycle
- dm_dout  out  DATA_W  load data, valid with dm_done
- mem_cmd  out  2  unified memory command
- mem_addr  out  ADDR_W  unified memory address
- mem_din  out  DATA_W  unified memory write data
- mem_dout  in  DATA_W  unified memory read data, valid with mem_ack
- mem_ack  in  1  memory completes the current command this cycle
- arb_stall  out  1  pipeline freeze request to the stalling module

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk. Reset values:
  - state IDLE; mem_cmd `BUS_NONE; mem_addr 0; mem_din 0.
  - if_vld 0; dm_done 0; arb_stall 0 while in reset.
- State machine, states IDLE, BUSY_IF, BUSY_DM. mem_cmd/mem_addr/mem_din are registered and held stable for the whole BUSY state.
- IDLE:
  - dm_cmd != `BUS_NONE → latch dm_cmd/dm_addr/dm_din, go to BUSY_DM.
  - else if_req → latch `BUS_LOAD/if_addr, go to BUSY_IF.
  - else stay in IDLE.
  - Data has priority: the MEM stage holds the older instruction.
- BUSY_x with mem_ack=0: hold state and all mem_* outputs.
- BUSY_x with mem_ack=1:
  - Pulse if_vld (BUSY_IF) or dm_done (BUSY_DM) combinationally for exactly one cycle.
  - Pass mem_dout through to if_inst or dm_dout.
  - On a store, dm_dout equals mem_dout and is don't-care.
- Ack-cycle arbitration:
  - The requester just served is masked for that cycle, because its request still shows the completed transaction.
  - If the other requester is pending, issue it directly (back-to-back, no IDLE bubble).
  - Otherwise go to IDLE with mem_cmd=`BUS_NONE.
  - Effect: when both requesters are continuously active, grants alternate and neither starves.
- Latency: a request seen in cycle N drives mem_cmd from cycle N+1. Minimum completion is N+1 with ack in the first command cycle.
- arb_stall = (if_req & ~if_vld) | ((dm_cmd != `BUS_NONE) & ~dm_done). It is purely combinational.
- mem_ack while in IDLE is ignored.
- Requests may change or drop while not granted. Once latched, the transaction completes regardless of later request changes.
- Reset mid-transaction: return to IDLE immediately with mem_cmd=`BUS_NONE and no completion pulse. The memory aborts the in-flight command.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds output ports perf_conflict_cnt[31:0] and perf_busy_cnt[31:0], both reset to 0.
  - perf_conflict_cnt increments each cycle both requesters are pending and at least one is not being completed.
  - perf_busy_cnt increments each cycle the state is not IDLE.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: arb_state_t enum (IDLE, BUSY_IF, BUSY_DM) and the arbiter grant-select typedef.
- Bus command encodings stay the existing `BUS_* defines in sys_defs.vh.
- Natural sub-module: mem_arb_perf, holding the two counters. It is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- if_req=1, if_addr=0x100, mem_ack 1 in the 2nd command cycle → mem_cmd=`BUS_LOAD, mem_addr=0x100 for 2 cycles; if_vld pulses once with if_inst=mem_dout=0x00500093; arb_stall=1 until that cycle.
- Same cycle: if_req=1 (0x104) and dm_cmd=`BUS_STORE (0x2000, din 0xDEADBEEF) → store issued first, dm_done on ack; fetch 0x104 issued next cycle with no IDLE gap.
- Both requesters held active for 6 transactions, ack after 1 cycle each → grants alternate DM, IF, DM, IF, DM, IF.
- dm_cmd=`BUS_LOAD at 0x3000, mem_ack held 0 for 5 cycles → mem_* stable for 5 cycles; dm_done=0, arb_stall=1 throughout; dm_dout=0x12345678 on the ack cycle.
- rst asserted during BUSY_DM → same cycle: mem_cmd=`BUS_NONE, state IDLE, no dm_done; a later stray mem_ack is ignored.
- With MEM_ARB_PERF_EN: 3 conflict cycles and 7 busy cycles → perf_conflict_cnt=3, perf_busy_cnt=7; rst clears both to 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state and grant select.
// The bus command encodings mirror the BUS_* defines of sys_defs.vh.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2
`endif

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_sel_t;

    // Data side wins ties: the MEM stage always holds the older instruction.
    function automatic grant_sel_t pick_grant(input logic if_pend, input logic dm_pend);
        grant_sel_t g;
        g = GNT_NONE;
        if (dm_pend)
            g = GNT_DM;
        else if (if_pend)
            g = GNT_IF;
        return g;
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Free-running 32-bit activity counters for the memory arbiter (conflicts, busy cycles).
// Both counters wrap at 2^32 and clear on rst.
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        conflict_i,
    input  logic        busy_i,
    output logic [31:0] conflict_cnt_o,
    output logic [31:0] busy_cnt_o
);

    logic [31:0] conflict_q, conflict_d;
    logic [31:0] busy_q, busy_d;

    always_comb begin
        conflict_d = conflict_q + {31'd0, conflict_i};
        busy_d     = busy_q + {31'd0, busy_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
            busy_q     <= '0;
        end else begin
            conflict_q <= conflict_d;
            busy_q     <= busy_d;
        end
    end

    assign conflict_cnt_o = conflict_q;
    assign busy_cnt_o     = busy_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one outstanding IF/MEM transaction onto the unified cmd/ack memory port.
// Optional perf counters are compiled in with MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_vld,
    output logic [DATA_W-1:0] if_inst,
    input  logic [1:0]        dm_cmd,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_din,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_dout,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ack,
    output logic              arb_stall
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_conflict_cnt,
    output logic [31:0]       perf_busy_cnt
`endif
);

    arb_state_t        state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    grant_sel_t        gnt;
    logic              issue;
    logic              dm_pend;

    assign dm_pend = (dm_cmd != `BUS_NONE);

    // The requester completing this cycle is masked: its request still shows the finished access.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        if_vld  = 1'b0;
        dm_done = 1'b0;
        gnt     = GNT_NONE;
        issue   = 1'b0;

        case (state_q)
            IDLE: begin
                issue = 1'b1;
                gnt   = pick_grant(if_req, dm_pend);
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    if_vld = 1'b1;
                    issue  = 1'b1;
                    gnt    = pick_grant(1'b0, dm_pend);
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    dm_done = 1'b1;
                    issue   = 1'b1;
                    gnt     = pick_grant(if_req, 1'b0);
                end
            end
            default: begin
                state_d = IDLE;
                cmd_d   = `BUS_NONE;
            end
        endcase

        if (issue) begin
            case (gnt)
                GNT_DM: begin
                    state_d = BUSY_DM;
                    cmd_d   = dm_cmd;
                    addr_d  = dm_addr;
                    din_d   = dm_din;
                end
                GNT_IF: begin
                    state_d = BUSY_IF;
                    cmd_d   = `BUS_LOAD;
                    addr_d  = if_addr;
                    din_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cmd_d   = `BUS_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= `BUS_NONE;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign mem_cmd  = cmd_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign if_inst  = mem_dout;
    assign dm_dout  = mem_dout;

    assign arb_stall = ~rst & ((if_req & ~if_vld) | (dm_pend & ~dm_done));

`ifdef MEM_ARB_PERF_EN
    logic perf_conflict;
    logic perf_busy;

    assign perf_conflict = if_req & dm_pend & ~(if_vld & dm_done);
    assign perf_busy     = (state_q != IDLE);

    mem_arb_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .conflict_i     (perf_conflict),
        .busy_i         (perf_busy),
        .conflict_cnt_o (perf_conflict_cnt),
        .busy_cnt_o     (perf_busy_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed literal cases plus randomized traffic against a transaction-level model.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2
`endif

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_vld;
    logic [31:0] if_inst;
    logic [1:0]  dm_cmd;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_done;
    logic [31:0] dm_dout;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;
    logic        arb_stall;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_busy_cnt;
    logic [31:0] p_conf;
    logic [31:0] p_busy;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_vld    (if_vld),
        .if_inst   (if_inst),
        .dm_cmd    (dm_cmd),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_done   (dm_done),
        .dm_dout   (dm_dout),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ack   (mem_ack),
        .arb_stall (arb_stall)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_busy_cnt     (perf_busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: at most one outstanding access, owned by IF or DM.
    bit          m_busy;
    bit          m_dm;
    logic [1:0]  m_cmd;
    logic [31:0] m_addr;
    logic [31:0] m_din;
    bit          chk_en = 1'b0;
    bit          e_ifv, e_dmd, dm_p, e_stall;

    task automatic model_issue_dm();
        m_busy = 1'b1; m_dm = 1'b1; m_cmd = dm_cmd; m_addr = dm_addr; m_din = dm_din;
    endtask

    task automatic model_issue_if();
        m_busy = 1'b1; m_dm = 1'b0; m_cmd = `BUS_LOAD; m_addr = if_addr; m_din = 32'h0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                check("rst_mem_cmd", {30'd0, mem_cmd}, {30'd0, `BUS_NONE});
                check("rst_mem_addr", mem_addr, 32'h0);
                check("rst_mem_din", mem_din, 32'h0);
                check("rst_if_vld", {31'd0, if_vld}, 32'd0);
                check("rst_dm_done", {31'd0, dm_done}, 32'd0);
                check("rst_stall", {31'd0, arb_stall}, 32'd0);
                m_busy = 1'b0;
`ifdef MEM_ARB_PERF_EN
                check("rst_perf_conf", perf_conflict_cnt, 32'd0);
                check("rst_perf_busy", perf_busy_cnt, 32'd0);
                p_conf = 32'd0;
                p_busy = 32'd0;
`endif
            end else begin
                dm_p    = (dm_cmd != `BUS_NONE);
                e_ifv   = m_busy && !m_dm && mem_ack;
                e_dmd   = m_busy && m_dm && mem_ack;
                e_stall = (if_req && !e_ifv) || (dm_p && !e_dmd);
                check("mem_cmd", {30'd0, mem_cmd}, {30'd0, (m_busy ? m_cmd : `BUS_NONE)});
                if (m_busy) check("mem_addr", mem_addr, m_addr);
                if (m_busy && m_dm) check("mem_din", mem_din, m_din);
                check("if_vld", {31'd0, if_vld}, {31'd0, e_ifv});
                check("dm_done", {31'd0, dm_done}, {31'd0, e_dmd});
                if (e_ifv) check("if_inst", if_inst, mem_dout);
                if (e_dmd && m_cmd == `BUS_LOAD) check("dm_dout", dm_dout, mem_dout);
                check("arb_stall", {31'd0, arb_stall}, {31'd0, e_stall});
`ifdef MEM_ARB_PERF_EN
                check("perf_conf", perf_conflict_cnt, p_conf);
                check("perf_busy", perf_busy_cnt, p_busy);
                if (if_req && dm_p && !(e_ifv && e_dmd)) p_conf = p_conf + 32'd1;
                if (m_busy) p_busy = p_busy + 32'd1;
`endif
                if (m_busy) begin
                    if (mem_ack) begin
                        m_busy = 1'b0;
                        if (m_dm && if_req) model_issue_if();
                        else if (!m_dm && dm_p) model_issue_dm();
                    end
                end else if (dm_p) begin
                    model_issue_dm();
                end else if (if_req) begin
                    model_issue_if();
                end
            end
        end
    end

    logic [31:0] alt_exp [6];

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; dm_cmd = `BUS_NONE; dm_addr = 0; dm_din = 0;
        mem_dout = 0; mem_ack = 0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fetch with ack in the second command cycle
        @(posedge clk); #1 if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        check("t1_stall_wait", {31'd0, arb_stall}, 32'd1);
        check("t1_cmd_idle", {30'd0, mem_cmd}, {30'd0, `BUS_NONE});
        @(posedge clk);
        @(negedge clk);
        check("t1_cmd_c1", {30'd0, mem_cmd}, {30'd0, `BUS_LOAD});
        check("t1_addr_c1", mem_addr, 32'h100);
        check("t1_vld_c1", {31'd0, if_vld}, 32'd0);
        @(posedge clk); #1 mem_ack = 1; mem_dout = 32'h00500093;
        @(negedge clk);
        check("t1_addr_c2", mem_addr, 32'h100);
        check("t1_vld_c2", {31'd0, if_vld}, 32'd1);
        check("t1_inst", if_inst, 32'h00500093);
        check("t1_stall_ack", {31'd0, arb_stall}, 32'd0);
        @(posedge clk); #1 if_req = 0; mem_ack = 0;
        @(negedge clk);
        check("t1_back_idle", {30'd0, mem_cmd}, {30'd0, `BUS_NONE});

        // Simultaneous store and fetch: store first, fetch back-to-back
        @(posedge clk); #1 if_req = 1; if_addr = 32'h104;
        dm_cmd = `BUS_STORE; dm_addr = 32'h2000; dm_din = 32'hDEADBEEF;
        @(posedge clk); #1 mem_ack = 1;
        @(negedge clk);
        check("t2_cmd_st", {30'd0, mem_cmd}, {30'd0, `BUS_STORE});
        check("t2_addr_st", mem_addr, 32'h2000);
        check("t2_din_st", mem_din, 32'hDEADBEEF);
        check("t2_done", {31'd0, dm_done}, 32'd1);
        @(posedge clk); #1 dm_cmd = `BUS_NONE;
        @(negedge clk);
        check("t2_cmd_if", {30'd0, mem_cmd}, {30'd0, `BUS_LOAD});
        check("t2_addr_if", mem_addr, 32'h104);
        check("t2_if_vld", {31'd0, if_vld}, 32'd1);
        @(posedge clk); #1 if_req = 0; mem_ack = 0;

        // Both requesters held: grants alternate DM, IF, ...
        alt_exp = '{32'h4000, 32'h200, 32'h4000, 32'h200, 32'h4000, 32'h200};
        @(posedge clk); #1 if_req = 1; if_addr = 32'h200;
        dm_cmd = `BUS_LOAD; dm_addr = 32'h4000; mem_ack = 1;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t3_grant%0d", k), mem_addr, alt_exp[k]);
        end
        @(posedge clk); #1 if_req = 0; dm_cmd = `BUS_NONE;
        @(posedge clk); #1 mem_ack = 0;

        // Slow load: mem_* held while ack is low
        @(posedge clk); #1 dm_cmd = `BUS_LOAD; dm_addr = 32'h3000;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_cmd_hold", {30'd0, mem_cmd}, {30'd0, `BUS_LOAD});
            check("t4_addr_hold", mem_addr, 32'h3000);
            check("t4_no_done", {31'd0, dm_done}, 32'd0);
            check("t4_stall", {31'd0, arb_stall}, 32'd1);
        end
        @(posedge clk); #1 mem_ack = 1; mem_dout = 32'h12345678;
        @(negedge clk);
        check("t4_done", {31'd0, dm_done}, 32'd1);
        check("t4_dout", dm_dout, 32'h12345678);
        @(posedge clk); #1 dm_cmd = `BUS_NONE; mem_ack = 0;

        // Reset mid-transaction, then a stray ack
        @(posedge clk); #1 dm_cmd = `BUS_STORE; dm_addr = 32'h5000; dm_din = 32'h1;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy", {30'd0, mem_cmd}, {30'd0, `BUS_STORE});
        @(posedge clk); #1 rst = 1; mem_ack = 1;
        #1;
        check("t5_rst_cmd", {30'd0, mem_cmd}, {30'd0, `BUS_NONE});
        check("t5_rst_done", {31'd0, dm_done}, 32'd0);
        @(posedge clk); #1 rst = 0; dm_cmd = `BUS_NONE;
        @(negedge clk);
        check("t5_stray_cmd", {30'd0, mem_cmd}, {30'd0, `BUS_NONE});
        check("t5_stray_done", {31'd0, dm_done}, 32'd0);
        check("t5_stray_vld", {31'd0, if_vld}, 32'd0);
        @(posedge clk); #1 mem_ack = 0;

`ifdef MEM_ARB_PERF_EN
        // 3 conflict cycles, 7 busy cycles
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1 if_req = 1; dm_cmd = `BUS_LOAD; dm_addr = 32'h6000;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 if_req = 0;
        repeat (4) @(posedge clk);
        #1 mem_ack = 1;
        @(posedge clk); #1 mem_ack = 0; dm_cmd = `BUS_NONE;
        @(negedge clk);
        check("t6_conf", perf_conflict_cnt, 32'd3);
        check("t6_busy", perf_busy_cnt, 32'd7);
        @(posedge clk); #1 rst = 1;
        #1;
        check("t6_rst_conf", perf_conflict_cnt, 32'd0);
        check("t6_rst_busy", perf_busy_cnt, 32'd0);
        @(posedge clk); #1 rst = 0;
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if_req   = ($urandom_range(0, 99) < 50);
            if_addr  = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: dm_cmd = `BUS_NONE;
                4, 5, 6:    dm_cmd = `BUS_LOAD;
                default:    dm_cmd = `BUS_STORE;
            endcase
            dm_addr  = $urandom;
            dm_din   = $urandom;
            mem_ack  = ($urandom_range(0, 99) < 40);
            mem_dout = $urandom;
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        rst = 0; if_req = 0; dm_cmd = `BUS_NONE; mem_ack = 1;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
